cache_arbiter: RTL

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_types_pkg.sv | 13 +
 rtl/cache_arbiter_mux.sv | 48 ++++
 rtl/cache_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/cache_types_pkg.sv
// Shared types for the I/D cache arbiter: FSM state encoding and
// default cache-line width.
package cache_types_pkg;

    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_mux.sv
// Steers the granted cache side onto the L2 bus and routes the L2
// response back to that side only.
module arbiter_mux
    import cache_types_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF
) (
    input  arb_state_t        grant,
    input  logic              ic_read,
    input  logic [31:0]       ic_address,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [31:0]       dc_address,
    input  logic [LINE_W-1:0] dc_wdata,
    input  logic              resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              ic_resp,
    output logic              dc_resp
);

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        ic_resp     = 1'b0;
        dc_resp     = 1'b0;
        case (grant)
            SERVE_I: begin
                mem_read    = ic_read;
                mem_address = ic_address;
                ic_resp     = resp;
            end
            SERVE_D: begin
                mem_read    = dc_read;
                mem_write   = dc_write;
                mem_address = dc_address;
                mem_wdata   = dc_wdata;
                dc_resp     = resp;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Two-way I/D cache arbiter onto a single L2 port. Fixed D priority by
// default; define CACHE_ARBITER_ROUND_ROBIN_EN for a toggling pointer.
module cache_arbiter
    import cache_types_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [31:0]       i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [31:0]       d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t state;
    arb_state_t grant;
    logic       d_req;
    logic       d_first;

    assign d_req = d_pmem_read | d_pmem_write;
    // Reset masks the bus immediately, even mid-transaction.
    assign grant = rst ? IDLE : state;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    logic prio_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_d <= 1'b1;
        end else if (state != IDLE && mem_resp) begin
            prio_d <= ~prio_d;
        end
    end
    assign d_first = prio_d;
`else
    assign d_first = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && (d_first || !i_pmem_read)) begin
                        state <= SERVE_D;
                    end else if (i_pmem_read) begin
                        state <= SERVE_I;
                    end
                end
                // Completion or requester abort both release the bus.
                SERVE_I: if (mem_resp || !i_pmem_read) state <= IDLE;
                SERVE_D: if (mem_resp || !d_req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

    arbiter_mux #(.LINE_W(LINE_W)) u_mux (
        .grant       (grant),
        .ic_read     (i_pmem_read),
        .ic_address  (i_pmem_address),
        .dc_read     (d_pmem_read),
        .dc_write    (d_pmem_write),
        .dc_address  (d_pmem_address),
        .dc_wdata    (d_pmem_wdata),
        .resp        (mem_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .ic_resp     (i_pmem_resp),
        .dc_resp     (d_pmem_resp)
    );

endmodule
